freq_gate_ctrl: RTL and testbench
=================================

// Module: freq_gate_ctrl
// PURPOSE
//  Reciprocal-count gate sequencer for the frequency-measurement path.
//  Opens and closes the measurement gate on edges of the measured signal.
//  Counts input periods (Nx) and reference cycles (Ns) over an integer number of input periods.
//  Publishes each Nx/Ns pair to the SPI readout through a valid/ack handshake.
//  Host computes f = f_clk * Nx / Ns.
// PARAMETERS
//  CNT_W           40           width of Nx/Ns counters and outputs
//  GATE_CYCLES     72_000_000   preset gate length in clk cycles (1 s @ 72 MHz), >=2
//  SYNC_STAGES     2            synchroniser flops on freq_in, >=2
//  TIMEOUT_CYCLES  144_000_000  no-edge limit in ARM/CLOSE (FREQ_TIMEOUT_EN only)
// PORTS
//  clk_72MHz  in   1      reference clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  enable     in   1      1 = run measurements back-to-back; 0 = abort/stay idle
//  freq_in    in   1      measured signal, asynchronous
//  nx_out     out  CNT_W  latched input-period count
//  ns_out     out  CNT_W  latched reference-cycle count
//  res_valid  out  1      result pending
//  res_ack    in   1      consumer took result (pulse or level)
//  overrun    out  1      a pending result was overwritten before ack (sticky)
//  gate_open  out  1      1 while in GATE or CLOSE
//  timeout    out  1      last result was a timeout (0 when macro off)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; synchroniser and counters 0.
//  Edge detect: edge = sync_q & ~sync_qd. Asserts SYNC_STAGES+1 cycles after a freq_in rise.
//  FSM:
//   IDLE:  enable=1 -> ARM.
//   ARM:   wait for edge.
//          On the edge cycle: Nx<=0, Ns<=0, preset<=0 -> GATE.
//   GATE:  each cycle Ns+=1, preset+=1; each edge Nx+=1.
//          preset reaching GATE_CYCLES -> CLOSE.
//          If an edge falls on that same cycle: count it -> LATCH directly.
//   CLOSE: each cycle Ns+=1; first edge: Nx+=1 -> LATCH.
//   LATCH: one cycle. nx_out<=Nx, ns_out<=Ns, res_valid<=1.
//          Then enable ? ARM : IDLE.
//          The closing edge is not reused as the next opening edge.
//  Ns = cycles from the opening edge (exclusive) to the closing edge (inclusive).
//  Counters saturate at all-ones; they do not wrap.
//  enable=0 in ARM/GATE/CLOSE: -> IDLE next cycle; no result published; outputs unchanged.
//  Handshake:
//   res_ack with res_valid=1 and no LATCH that cycle: res_valid<=0, overrun<=0.
//   LATCH while res_valid=1 and no ack: overrun<=1; new data overwrites.
//   LATCH and ack in the same cycle: new data, res_valid stays 1, overrun<=0.
//   res_ack with res_valid=0: ignored.
//  Async reset mid-measurement: immediate return to reset state; partial counts discarded.
// CONFIGURATION
//  FREQ_TIMEOUT_EN defined:
//   A watchdog clears on every edge and on entry to ARM.
//   It counts cycles in ARM/CLOSE; at TIMEOUT_CYCLES -> LATCH with nx_out=0, ns_out=0, timeout<=1.
//   A normal LATCH sets timeout<=0.
//  FREQ_TIMEOUT_EN undefined: no watchdog logic; timeout tied 0; ARM/CLOSE wait indefinitely.
// TESTING (GATE_CYCLES=100, SYNC_STAGES=2, TIMEOUT_CYCLES=300)
//  1. freq_in period 10 clk, enable=1 -> nx_out=10, ns_out=100, res_valid=1 (closing edge on expiry).
//  2. period 7 clk -> nx_out=15, ns_out=105; gate_open high for exactly 105 cycles.
//  3. Two results, no res_ack -> overrun=1, second values present.
//     Then res_ack -> res_valid=0, overrun=0 next cycle.
//  4. enable=0 mid-GATE -> IDLE next cycle, gate_open=0, res_valid stays 0.
//     Re-enable -> fresh result correct.
//  5. rst_n low mid-CLOSE -> all outputs 0 immediately (asynchronously).
//     After release, first result is identical to scenario 1.
//  6. FREQ_TIMEOUT_EN, freq_in stuck 0 -> after 300 cycles in ARM: res_valid=1, timeout=1, nx_out=ns_out=0.
//     Macro off: res_valid stays 0.

Source files
------------

// File: rtl/freq_gate_ctrl.sv
// Reciprocal-count gate sequencer: counts Nx input periods and Ns clk cycles.
// Optional no-edge watchdog enabled by defining FREQ_TIMEOUT_EN.
module freq_gate_ctrl #(
  parameter int CNT_W          = 40,
  parameter int GATE_CYCLES    = 72_000_000,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 144_000_000
) (
  input  logic             clk_72MHz,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             freq_in,
  output logic [CNT_W-1:0] nx_out,
  output logic [CNT_W-1:0] ns_out,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             overrun,
  output logic             gate_open,
  output logic             timeout
);

  localparam int PW = $clog2(GATE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, ARM, GATE, CLOSE, LATCH
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_qd;
  logic                   edge_det;
  logic [CNT_W-1:0]       nx, ns;
  logic [PW-1:0]          preset;
  logic                   preset_hit;
  logic                   wd_fire;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk_72MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      sync_qd <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], freq_in};
      sync_qd <= sync[SYNC_STAGES-1];
    end
  end

  assign edge_det   = sync[SYNC_STAGES-1] & ~sync_qd;
  assign preset_hit = (preset + PW'(1)) == PW'(GATE_CYCLES);
  assign gate_open  = (state == GATE) || (state == CLOSE);

`ifdef FREQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd;
  logic          to_pend;

  assign wd_fire = ((state == ARM) || (state == CLOSE)) && !edge_det &&
                   ((wd + WW'(1)) == WW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_72MHz or negedge rst_n) begin
    if (!rst_n) begin
      wd      <= '0;
      to_pend <= 1'b0;
    end else begin
      to_pend <= wd_fire;
      if (edge_det || (state_n == ARM && state != ARM))
        wd <= '0;
      else if (state == ARM || state == CLOSE)
        wd <= wd + WW'(1);
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_72MHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (enable) state_n = ARM;
      ARM: begin
        if (!enable)       state_n = IDLE;
        else if (edge_det) state_n = GATE;
        else if (wd_fire)  state_n = LATCH;
      end
      GATE: begin
        if (!enable)         state_n = IDLE;
        else if (preset_hit) state_n = edge_det ? LATCH : CLOSE;
      end
      CLOSE: begin
        if (!enable)       state_n = IDLE;
        else if (edge_det) state_n = LATCH;
        else if (wd_fire)  state_n = LATCH;
      end
      LATCH: state_n = enable ? ARM : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_72MHz or negedge rst_n) begin
    if (!rst_n) begin
      nx     <= '0;
      ns     <= '0;
      preset <= '0;
    end else begin
      unique case (state)
        ARM: begin
          if (edge_det) begin
            nx     <= '0;
            ns     <= '0;
            preset <= '0;
          end
        end
        GATE: begin
          ns     <= sat_inc(ns);
          preset <= preset + PW'(1);
          if (edge_det) nx <= sat_inc(nx);
        end
        CLOSE: begin
          ns <= sat_inc(ns);
          if (edge_det) nx <= sat_inc(nx);
        end
        default: ;
      endcase
    end
  end

  // LATCH overwrites pending data; a same-cycle ack clears overrun
  always_ff @(posedge clk_72MHz or negedge rst_n) begin
    if (!rst_n) begin
      nx_out    <= '0;
      ns_out    <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef FREQ_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
    end else if (state == LATCH) begin
`ifdef FREQ_TIMEOUT_EN
      if (to_pend) begin
        nx_out  <= '0;
        ns_out  <= '0;
        timeout <= 1'b1;
      end else begin
        nx_out  <= nx;
        ns_out  <= ns;
        timeout <= 1'b0;
      end
`else
      nx_out <= nx;
      ns_out <= ns;
`endif
      res_valid <= 1'b1;
      if (res_ack)        overrun <= 1'b0;
      else if (res_valid) overrun <= 1'b1;
    end else if (res_ack && res_valid) begin
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl (GATE_CYCLES=100, SYNC_STAGES=2).
// Timeout scenario expectations follow FREQ_TIMEOUT_EN.
module tb_freq_gate_ctrl;

  localparam int CNT_W = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             freq_in;
  logic [CNT_W-1:0] nx_out;
  logic [CNT_W-1:0] ns_out;
  logic             res_valid;
  logic             res_ack;
  logic             overrun;
  logic             gate_open;
  logic             timeout;

  int checks = 0;
  int fails  = 0;
  int per    = 0;

  freq_gate_ctrl #(
    .CNT_W(CNT_W),
    .GATE_CYCLES(100),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(300)
  ) dut (
    .clk_72MHz(clk),
    .rst_n(rst_n),
    .enable(enable),
    .freq_in(freq_in),
    .nx_out(nx_out),
    .ns_out(ns_out),
    .res_valid(res_valid),
    .res_ack(res_ack),
    .overrun(overrun),
    .gate_open(gate_open),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin : gen
    int cnt;
    cnt = 0;
    freq_in = 1'b0;
    forever begin
      @(negedge clk);
      if (per == 0) begin
        cnt = 0;
        freq_in = 1'b0;
      end else begin
        freq_in = (cnt < per / 2);
        cnt = (cnt + 1 >= per) ? 0 : cnt + 1;
      end
    end
  end

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic idle_clear();
    enable = 1'b0;
    per = 0;
    repeat (4) @(negedge clk);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    res_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (nx_out !== '0) begin fails++; $display("FAIL rst_nx got %0d exp 0", nx_out); end
    if (ns_out !== '0) begin fails++; $display("FAIL rst_ns got %0d exp 0", ns_out); end
    if (res_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", res_valid); end
    if (overrun !== 1'b0) begin fails++; $display("FAIL rst_overrun got %b exp 0", overrun); end
    if (gate_open !== 1'b0) begin fails++; $display("FAIL rst_gate got %b exp 0", gate_open); end
    if (timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout got %b exp 0", timeout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_period10();
    bit ok;
    per = 10;
    enable = 1'b1;
    wait_valid(400, ok);
    checks += 4;
    if (!ok) begin fails++; $display("FAIL p10_wait got no valid exp valid"); end
    if (nx_out !== 40'd10) begin fails++; $display("FAIL p10_nx got %0d exp 10", nx_out); end
    if (ns_out !== 40'd100) begin fails++; $display("FAIL p10_ns got %0d exp 100", ns_out); end
    if (timeout !== 1'b0) begin fails++; $display("FAIL p10_timeout got %b exp 0", timeout); end
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin fails++; $display("FAIL p10_ack got %b exp 0", res_valid); end
  endtask

  task automatic test_period7();
    bit ok;
    int gcnt;
    idle_clear();
    per = 7;
    enable = 1'b1;
    gcnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (gate_open) gcnt++;
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks += 4;
    if (!ok) begin fails++; $display("FAIL p7_wait got no valid exp valid"); end
    if (nx_out !== 40'd15) begin fails++; $display("FAIL p7_nx got %0d exp 15", nx_out); end
    if (ns_out !== 40'd105) begin fails++; $display("FAIL p7_ns got %0d exp 105", ns_out); end
    if (gcnt != 105) begin fails++; $display("FAIL p7_gate_len got %0d exp 105", gcnt); end
  endtask

  task automatic test_overrun();
    bit ok;
    idle_clear();
    per = 10;
    enable = 1'b1;
    wait_valid(400, ok);
    per = 0;
    repeat (5) @(negedge clk);
    per = 7;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (overrun) begin
        ok = 1'b1;
        break;
      end
    end
    checks += 4;
    if (!ok) begin fails++; $display("FAIL ovr_flag got 0 exp 1"); end
    if (res_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid got %b exp 1", res_valid); end
    if (nx_out !== 40'd15) begin fails++; $display("FAIL ovr_nx got %0d exp 15", nx_out); end
    if (ns_out !== 40'd105) begin fails++; $display("FAIL ovr_ns got %0d exp 105", ns_out); end
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    checks += 2;
    if (res_valid !== 1'b0) begin fails++; $display("FAIL ovr_ack_valid got %b exp 0", res_valid); end
    if (overrun !== 1'b0) begin fails++; $display("FAIL ovr_ack_flag got %b exp 0", overrun); end
  endtask

  task automatic test_abort();
    bit ok;
    idle_clear();
    per = 10;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gate_open) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin fails++; $display("FAIL abort_open got 0 exp 1"); end
    repeat (20) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks += 2;
    if (gate_open !== 1'b0) begin fails++; $display("FAIL abort_gate got %b exp 0", gate_open); end
    if (res_valid !== 1'b0) begin fails++; $display("FAIL abort_valid got %b exp 0", res_valid); end
    repeat (150) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0) begin fails++; $display("FAIL abort_idle got %b exp 0", res_valid); end
    enable = 1'b1;
    wait_valid(400, ok);
    checks += 3;
    if (!ok) begin fails++; $display("FAIL abort_rerun got no valid exp valid"); end
    if (nx_out !== 40'd10) begin fails++; $display("FAIL abort_nx got %0d exp 10", nx_out); end
    if (ns_out !== 40'd100) begin fails++; $display("FAIL abort_ns got %0d exp 100", ns_out); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    idle_clear();
    per = 7;
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gate_open) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (101) @(negedge clk);
    checks++;
    if (!ok || gate_open !== 1'b1) begin fails++; $display("FAIL rmid_close got %b exp 1", gate_open); end
    #2 rst_n = 1'b0;
    #1;
    checks += 4;
    if (gate_open !== 1'b0) begin fails++; $display("FAIL rmid_gate got %b exp 0", gate_open); end
    if (nx_out !== '0) begin fails++; $display("FAIL rmid_nx got %0d exp 0", nx_out); end
    if (ns_out !== '0) begin fails++; $display("FAIL rmid_ns got %0d exp 0", ns_out); end
    if (res_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b exp 0", res_valid); end
    enable = 1'b0;
    per = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    per = 10;
    enable = 1'b1;
    wait_valid(400, ok);
    checks += 3;
    if (!ok) begin fails++; $display("FAIL rmid_rerun got no valid exp valid"); end
    if (nx_out !== 40'd10) begin fails++; $display("FAIL rmid_nx2 got %0d exp 10", nx_out); end
    if (ns_out !== 40'd100) begin fails++; $display("FAIL rmid_ns2 got %0d exp 100", ns_out); end
  endtask

  task automatic test_timeout();
    bit ok;
    idle_clear();
    enable = 1'b1;
`ifdef FREQ_TIMEOUT_EN
    wait_valid(400, ok);
    checks += 4;
    if (!ok) begin fails++; $display("FAIL to_valid got 0 exp 1"); end
    if (timeout !== 1'b1) begin fails++; $display("FAIL to_flag got %b exp 1", timeout); end
    if (nx_out !== '0) begin fails++; $display("FAIL to_nx got %0d exp 0", nx_out); end
    if (ns_out !== '0) begin fails++; $display("FAIL to_ns got %0d exp 0", ns_out); end
`else
    wait_valid(400, ok);
    checks += 2;
    if (ok) begin fails++; $display("FAIL to_valid got 1 exp 0"); end
    if (timeout !== 1'b0) begin fails++; $display("FAIL to_flag got %b exp 0", timeout); end
`endif
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_period10();
    test_period7();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
